// File: rtl/sweep_resp_reader.sv
// Purpose: drives a 5-bit stimulus sweep (31 down to 0) into a DUT and folds its responses into an 8-bit MISR.
// Latency: 32*(SETTLE+1) cycles from the start edge to the one-cycle done pulse; pass follows one cycle later.
// Backpressure: none; start is ignored while busy or in DONE, abort cancels a running sweep on the next edge.
module sweep_resp_reader #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] resp_b,
    input  logic       resp_e,
    input  logic [7:0] golden,
    output logic [3:0] stim_a,
    output logic       stim_d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] sig
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [4:0] vec;
    logic [7:0] sig_next;

    // MISR step: feedback taps 7,5,4,3 shifted into bit 0, response folded into the low five bits.
    always_comb begin
        sig_next = {sig[6:0], sig[7] ^ sig[5] ^ sig[4] ^ sig[3]} ^ {3'b000, resp_e, resp_b};
    end

    // The vector register is the stimulus output itself, so stim is registered by construction.
    assign {stim_d, stim_a} = vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            vec   <= 5'd0;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            sig   <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec   <= 5'h1f;
                        cnt   <= SETTLE_CNT;
                        sig   <= 8'h00;
                        pass  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Abort wins over a sample landing on the same edge; sig keeps its partial value.
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        vec   <= 5'd0;
                        pass  <= 1'b0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        sig <= sig_next;
                        if (vec != 5'd0) begin
                            vec <= vec - 5'd1;
                            cnt <= SETTLE_CNT;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            vec   <= 5'd0;
                        end
                    end
                end
                ST_DONE: begin
                    pass  <= (sig == golden);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    vec   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_resp_reader.sv
// Directed bench for sweep_resp_reader with SETTLE=2: reset, full sweeps, loopback MISR, abort and mid-sweep reset.
module tb_sweep_resp_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       loop_en;
    logic [7:0] golden;
    logic [3:0] resp_b;
    logic       resp_e;
    logic [3:0] stim_a;
    logic       stim_d;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] sig;

    int checks = 0;
    int errors = 0;

    assign resp_b = loop_en ? stim_a : 4'h0;
    assign resp_e = loop_en ? stim_d : 1'b0;

    sweep_resp_reader #(.SETTLE(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .resp_b (resp_b),
        .resp_e (resp_e),
        .golden (golden),
        .stim_a (stim_a),
        .stim_d (stim_d),
        .busy   (busy),
        .done   (done),
        .pass   (pass),
        .sig    (sig)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {16'h0, stim_d, stim_a, busy, done, pass, sig}, 32'h0);
    endtask

    // Reference MISR over vectors 31 down to lo, starting from zero, with response = vector.
    function automatic logic [7:0] model(input int lo);
        logic [7:0] s;
        logic [4:0] vv;
        s = 8'h00;
        for (int v = 31; v >= lo; v--) begin
            vv = v[4:0];
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {3'b000, vv};
        end
        return s;
    endfunction

    // Full sweep from IDLE; optionally re-pulses start during cycle restart_at to show it is ignored.
    task automatic run_sweep(input logic [7:0] exp_sig, input logic exp_pass, input int restart_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 96; k++) begin
            chk("stim_sched", {27'h0, stim_d, stim_a}, 32'(31 - k / 3));
            chk("busy_sweep", {31'h0, busy}, 32'h1);
            chk("done_early", {31'h0, done}, 32'h0);
            start = (k == restart_at);
            tick();
        end
        start = 1'b0;
        chk("done_pulse", {31'h0, done}, 32'h1);
        chk("busy_done", {31'h0, busy}, 32'h0);
        chk("stim_done", {27'h0, stim_d, stim_a}, 32'h0);
        chk("sig_final", {24'h0, sig}, {24'h0, exp_sig});
        tick();
        chk("done_one_cycle", {31'h0, done}, 32'h0);
        chk("pass", {31'h0, pass}, {31'h0, exp_pass});
        chk("busy_idle", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        loop_en = 1'b0;
        golden  = 8'h00;
        #3;
        chk_zero("reset_async");
        tick();
        chk_zero("reset_held");
        rst_n = 1'b1;
        repeat (3) tick();
        chk_zero("idle_no_start");

        // Responses tied low: signature stays zero.
        run_sweep(8'h00, 1'b1, -1);
        // Back-to-back with a mismatching golden.
        golden = 8'h01;
        run_sweep(8'h00, 1'b0, -1);
        // Loopback, with a start re-issued mid-sweep.
        loop_en = 1'b1;
        golden  = model(0);
        run_sweep(model(0), 1'b1, 40);

        // Abort on the sample edge of vector 20.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (35) tick();
        chk("abort_pre_stim", {27'h0, stim_d, stim_a}, 32'd20);
        chk("abort_pre_sig", {24'h0, sig}, {24'h0, model(21)});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_stim", {27'h0, stim_d, stim_a}, 32'h0);
        chk("abort_sig_kept", {24'h0, sig}, {24'h0, model(21)});
        chk("abort_pass", {31'h0, pass}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", {31'h0, done}, 32'h0);
            chk("abort_stays_idle", {31'h0, busy}, 32'h0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_noop_busy", {31'h0, busy}, 32'h0);
        chk("abort_idle_noop_sig", {24'h0, sig}, {24'h0, model(21)});

        // Reset asserted mid-sweep at vector 10.
        loop_en = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (64) tick();
        chk("rst_pre_stim", {27'h0, stim_d, stim_a}, 32'd10);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid_async");
        tick();
        chk_zero("rst_mid_held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_zero("rst_release_idle");
            tick();
        end
        golden = 8'h00;
        run_sweep(8'h00, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_resp_reader.md
SWEEP_RESP_READER -- requirements
Module: sweep_resp_reader

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning idle cycles each stimulus vector is held before its response is sampled (legal 0..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start  input  1  begin sweep; sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a running sweep.
REQ-006 SHALL have port resp_b  input  4  DUT data response.
REQ-007 SHALL have port resp_e  input  1  DUT flag response.
REQ-008 SHALL have port golden  input  8  expected final signature; sampled in DONE.
REQ-009 SHALL have port stim_a  output  4  stimulus data to DUT.
REQ-010 SHALL have port stim_d  output  1  stimulus control bit to DUT.
REQ-011 SHALL have port busy  output  1  high while sweeping.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port pass  output  1  signature compare result, held until next start.
REQ-014 SHALL have port sig  output  8  current MISR signature.

Function
REQ-015 SHALL implement states IDLE, DRIVE, DONE; all outputs registered.
REQ-016 SHALL, in IDLE with start=1, load vec={stim_d,stim_a}=5'b11111, cnt=SETTLE, sig=0, pass=0, busy=1, and enter DRIVE.
REQ-017 SHALL, in DRIVE with cnt!=0, decrement cnt and hold vec.
REQ-018 SHALL, in DRIVE with cnt==0, update sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ {3'b000, resp_e, resp_b}.
REQ-019 SHALL, on that same edge, if vec!=0 decrement vec by 1 and reload cnt=SETTLE; if vec==0 enter DONE.
REQ-020 SHALL hold each vector for exactly SETTLE+1 cycles; the sweep runs 31 down to 0, 32*(SETTLE+1) cycles from the start edge to DONE entry.
REQ-021 SHALL, in DONE, assert done=1 for exactly one cycle, register pass=(sig==golden), deassert busy, and return to IDLE on the next edge.
REQ-022 SHALL drive stim_a=0 and stim_d=0 in IDLE and DONE.
REQ-023 SHALL ignore start while busy=1 and in DONE.
REQ-024 SHALL, on abort=1 in DRIVE, return to IDLE next edge with busy=0, stim=0, done not pulsed, pass=0, sig retained.
REQ-025 SHALL give abort priority over a sample on the same edge; abort in IDLE or DONE has no effect.
REQ-026 SHALL allow a start in the IDLE cycle immediately after DONE (back-to-back sweeps).

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, stim_a=0, stim_d=0, busy=0, done=0, pass=0, sig=8'h00, cnt=0.
REQ-028 SHALL resume from IDLE after rst_n release, including reset asserted mid-sweep; no done pulse is generated.

Verification
REQ-029 SHALL cover: rst_n low -> all outputs 0; release, no start -> outputs remain 0.
REQ-030 SHALL cover: SETTLE=2, start pulse, resp tied 0, golden=8'h00 -> stim 31..0 each held 3 cycles, done one cycle at 96 cycles after start edge, sig=8'h00, pass=1.
REQ-031 SHALL cover: same sweep, golden=8'h01 -> done pulses, pass=0.
REQ-032 SHALL cover: resp={stim_d,stim_a} looped back -> final sig equals the bench model of REQ-018; pass=1 with golden set to that value.
REQ-033 SHALL cover: abort while vec=20 -> IDLE next edge, busy=0, stim=0, no done; start re-issued mid-sweep -> ignored.
REQ-034 SHALL cover: rst_n pulsed low mid-sweep at vec=10 -> immediate reset values; fresh start completes normally.
